mult_arbiter: RTL

- Round-robin arbiter and sequencer that shares one shift-add multiplier between NUM_REQ requesters.
- Grants one requester at a time and captures its operands. Runs the multiply for exactly WIDTH cycles, then returns the product tagged with the requester index.
- Sits between several client FSMs and a single multiplier datapath, so the design needs only one multiplier instance.

---
 rtl/mult_arb_pkg.sv | 45 ++++
 rtl/mult_arbiter_shift_add_core.sv | 55 +++++
 rtl/mult_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg
// Shared types and helpers for the multiplier arbiter:
//   state_e    - sequencer states (IDLE -> CALC -> DONE -> IDLE)
//   DEF_*      - default operand width and requester count
//   rr_pick()  - round-robin winner search over a request vector
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_NUM_REQ = 4;

    // Upper bound on requesters the pick helper can scan.
    localparam int MAX_REQ  = 32;
    localparam int MAX_ID_W = 5;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req at or above ptr, wrapping modulo num_req.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                         input int                 num_req,
                                         input int                 ptr);
        rr_pick_t r;
        int       k;
        r = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < num_req && !r.valid) begin
                k = (ptr + i) % num_req;
                if (req[MAX_ID_W'(k)]) begin
                    r.valid = 1'b1;
                    r.idx   = MAX_ID_W'(k);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_arbiter_shift_add_core.sv
// shift_add_core
// Sequential shift-add multiplier: one partial product per step.
// Ports:
//   clk, reset (async, active-low)
//   load       - capture a/b, clear accumulator and bit counter
//   a, b       - WIDTH-bit unsigned operands
//   step       - accumulate the partial product for the current bit
//   acc        - 2*WIDTH-bit running product
//   count_done - high while the current step handles the last bit of b
module shift_add_core
    import mult_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               step,
    output logic [2*WIDTH-1:0] acc,
    output logic               count_done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] w_addend;

    // Width-extend before shifting so high partial-product bits are kept.
    assign w_addend   = r_b[r_cnt] ? ((2*WIDTH)'(r_a) << r_cnt) : '0;
    assign count_done = (r_cnt == CNT_W'(WIDTH - 1));
    assign acc        = r_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (step) begin
            r_acc <= r_acc + w_addend;
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter
// Round-robin arbiter sharing one shift-add multiplier among NUM_REQ clients.
// Ports:
//   clk, reset (async, active-low)
//   req      - per-requester request level (sampled only in IDLE)
//   a_in     - packed multiplicands, slice i for requester i
//   b_in     - packed multipliers, slice i for requester i
//   gnt      - one-hot pulse in the cycle operands are captured
//   done     - one-hot pulse in the cycle the product is valid
//   product  - result of the last completed operation
//   prod_id  - requester index of the last completed operation
//   busy     - high in CALC and DONE
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] a_in,
    input  logic [NUM_REQ*WIDTH-1:0] b_in,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic [2*WIDTH-1:0]       product,
    output logic [ID_W-1:0]          prod_id,
    output logic                     busy
);

    state_e             r_state;
    state_e             w_next;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    r_prod_id;
    logic [2*WIDTH-1:0] r_product;

    rr_pick_t           w_pick;
    logic [ID_W-1:0]    w_win_id;
    logic [WIDTH-1:0]   w_a_sel;
    logic [WIDTH-1:0]   w_b_sel;
    logic               w_load;
    logic               w_step;
    logic               w_count_done;
    logic [2*WIDTH-1:0] w_acc;

    assign w_pick   = rr_pick(MAX_REQ'(req), NUM_REQ, int'(r_rr_ptr));
    assign w_win_id = ID_W'(w_pick.idx);
    assign w_a_sel  = a_in[w_win_id*WIDTH +: WIDTH];
    assign w_b_sel  = b_in[w_win_id*WIDTH +: WIDTH];

    shift_add_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .load       (w_load),
        .a          (w_a_sel),
        .b          (w_b_sel),
        .step       (w_step),
        .acc        (w_acc),
        .count_done (w_count_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr  <= '0;
            r_id      <= '0;
            r_prod_id <= '0;
            r_product <= '0;
        end else begin
            if (w_load) begin
                r_id <= w_win_id;
            end
            if (r_state == DONE) begin
                r_product <= w_acc;
                r_prod_id <= r_id;
                r_rr_ptr  <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        gnt    = '0;
        done   = '0;
        w_load = 1'b0;
        w_step = 1'b0;
        busy   = 1'b0;
        case (r_state)
            IDLE: begin
                // Gated by reset so no grant is shown while the block is held in reset.
                if (w_pick.valid && reset) begin
                    gnt    = NUM_REQ'(1) << w_win_id;
                    w_load = 1'b1;
                    w_next = CALC;
                end
            end
            CALC: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (w_count_done) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                busy   = 1'b1;
                done   = NUM_REQ'(1) << r_id;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // In DONE the accumulator is already final; the registers hold it afterwards.
    assign product = (r_state == DONE) ? w_acc : r_product;
    assign prod_id = (r_state == DONE) ? r_id  : r_prod_id;

endmodule
